spu_result_writer: RTL

SPU_RESULT_WRITER -- requirements
Module: spu_result_writer

---
 rtl/spu_result_writer_pkg.sv | 17 +
 rtl/spu_result_fifo.sv | 59 +++++
 rtl/spu_result_writer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spu_result_writer_pkg.sv
// Shared types and helpers for the SPU result writer.
package spu_result_writer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } spu_state_e;

    // Width of one packed SRAM word: LANES pairs of (s_data0, s_data1).
    function automatic int unsigned packed_word_bits(input int unsigned lanes,
                                                     input int unsigned data_bits);
        return 2 * lanes * data_bits;
    endfunction

endpackage

// File: rtl/spu_result_fifo.sv
// Synchronous show-ahead FIFO holding packed result words ahead of the SRAM port.
module spu_result_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_BITS-1:0] count_q;
    logic                do_push, do_pop;

    assign full     = (count_q == CNT_BITS'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Storage carries no reset; its contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_BITS'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/spu_result_writer.sv
// Packs LANES upstream result pairs per SRAM word and streams word_count words
// to consecutive addresses from base_addr, throttling upstream via up_cke.
module spu_result_writer
    import spu_result_writer_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_BITS-1:0]            s_data0,
    input  logic [DATA_BITS-1:0]            s_data1,
    input  logic                            s_valid,
    output logic                            up_cke,
    input  logic                            start,
    input  logic [ADDR_BITS-1:0]            base_addr,
    input  logic [ADDR_BITS:0]              word_count,
    output logic                            busy,
    output logic                            done,
    output logic                            m_wr_en,
    output logic [ADDR_BITS-1:0]            m_wr_addr,
    output logic [2*LANES*DATA_BITS-1:0]    m_wr_data,
    input  logic                            m_wr_ready
);

    localparam int unsigned WORD_BITS = packed_word_bits(LANES, DATA_BITS);
    localparam int unsigned LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CNT_BITS  = $clog2(FIFO_DEPTH) + 1;

    spu_state_e          state_q, state_d;
    logic                busy_q, done_q;
    logic [ADDR_BITS:0]  word_count_q, words_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LANE_BITS-1:0] lane_q;
    logic [WORD_BITS-1:0] pack_q, pack_d;
    logic                consume, last_lane, push, pop, drain_empty;
    logic                fifo_full, fifo_empty;
    logic [CNT_BITS-1:0] fifo_count;

    // up_cke decodes registers only: no combinational path from s_valid or m_wr_ready.
    assign up_cke    = (state_q == StRun) && !fifo_full;
    assign consume   = s_valid && up_cke;
    assign last_lane = (lane_q == LANE_BITS'(LANES - 1));
    assign push      = consume && last_lane;
    assign m_wr_en   = !fifo_empty;
    assign pop       = m_wr_en && m_wr_ready;
    assign m_wr_addr = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // The final word leaving this cycle counts as drained, so done follows the last write.
    assign drain_empty = fifo_empty || ((fifo_count == CNT_BITS'(1)) && pop);

    always_comb begin
        pack_d = pack_q;
        pack_d[32'(lane_q) * 2 * DATA_BITS +: 2 * DATA_BITS] = {s_data1, s_data0};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (word_count == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (push && ((words_q + (ADDR_BITS + 1)'(1)) == word_count_q)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_empty) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_count_q <= '0;
            words_q      <= '0;
            addr_q       <= '0;
            lane_q       <= '0;
            pack_q       <= '0;
        end else if ((state_q == StIdle) && start) begin
            word_count_q <= word_count;
            words_q      <= '0;
            addr_q       <= base_addr;
            lane_q       <= '0;
        end else begin
            if (pop) begin
                addr_q <= addr_q + ADDR_BITS'(1);
            end
            if (consume) begin
                pack_q <= pack_d;
                if (last_lane) begin
                    lane_q  <= '0;
                    words_q <= words_q + (ADDR_BITS + 1)'(1);
                end else begin
                    lane_q <= lane_q + LANE_BITS'(1);
                end
            end
        end
    end

    spu_result_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (pack_d),
        .pop       (pop),
        .pop_data  (m_wr_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule
